// File: rtl/bit_fifo_hs.sv
// bit_fifo_hs: variable-bit-count FIFO with independent write/read widths
// and valid/ready handshakes. Storage is LSB-first (bit 0 = oldest).
// Optional stall statistics: define BIT_FIFO_HS_STATS_EN.
module bit_fifo_hs #(
  parameter int IN_W      = 48,
  parameter int OUT_W     = 48,
  parameter int FIFO_W    = 192,
  parameter int AFULL_LVL = FIFO_W - IN_W,
  parameter int CNT_W     = $clog2(FIFO_W + 1),
  parameter int IN_CNT_W  = $clog2(IN_W + 1),
  parameter int OUT_CNT_W = $clog2(OUT_W + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  input  logic [IN_W-1:0]      i_in_data,
  input  logic [IN_CNT_W-1:0]  i_in_nbits,
  output logic                 o_in_ready,
  output logic                 o_wr_err,
  input  logic                 i_rd_req,
  input  logic [OUT_CNT_W-1:0] i_rd_nbits,
  output logic                 o_rd_valid,
  output logic [OUT_W-1:0]     o_rd_data,
  output logic                 o_rd_err,
  output logic [CNT_W-1:0]     o_level,
  output logic                 o_empty,
`ifdef BIT_FIFO_HS_STATS_EN
  output logic [15:0]          o_wr_stall_cnt,
  output logic [15:0]          o_rd_stall_cnt,
`endif
  output logic                 o_almost_full
);

  // One extra bit so level + in_nbits can never wrap.
  localparam logic [CNT_W:0] IN_LIM  = (CNT_W+1)'(IN_W);
  localparam logic [CNT_W:0] OUT_LIM = (CNT_W+1)'(OUT_W);
  localparam logic [CNT_W:0] CAP     = (CNT_W+1)'(FIFO_W);
  localparam logic [CNT_W:0] AF_LIM  = (CNT_W+1)'(AFULL_LVL);

  logic [FIFO_W-1:0] r_storage;
  logic [CNT_W-1:0]  r_level;

  logic [CNT_W:0]    w_lvl, w_in_n, w_rd_n, w_rd_eff, w_wr_eff, w_wr_pos;
  logic              w_in_ok, w_rd_ok, w_rd_acc, w_wr_acc;
  logic [IN_W-1:0]   w_in_mask;
  logic [OUT_W-1:0]  w_out_mask;
  logic [FIFO_W-1:0] w_in_ext;

  assign w_lvl   = {1'b0, r_level};
  assign w_in_n  = (CNT_W+1)'(i_in_nbits);
  assign w_rd_n  = (CNT_W+1)'(i_rd_nbits);
  assign w_in_ok = (w_in_n <= IN_LIM);
  assign w_rd_ok = (w_rd_n <= OUT_LIM);

  assign o_wr_err = i_in_valid & ~w_in_ok;
  assign o_rd_err = i_rd_req & ~w_rd_ok;

  // Read side: rd_valid ignores rd_req; flush and oversize requests block it.
  assign o_rd_valid = ~i_flush & (w_lvl >= w_rd_n) & w_rd_ok;
  assign w_rd_acc   = i_rd_req & o_rd_valid;
  assign w_rd_eff   = w_rd_acc ? w_rd_n : '0;

  // Space freed by a same-cycle read is usable by the write.
  assign o_in_ready = ~i_flush & w_in_ok & ((w_lvl - w_rd_eff + w_in_n) <= CAP);
  assign w_wr_acc   = i_in_valid & o_in_ready;
  assign w_wr_eff   = w_wr_acc ? w_in_n : '0;

  // Shift-by-width yields zero, so the complement gives an all-ones mask at n = W.
  assign w_in_mask  = ~({IN_W{1'b1}} << w_wr_eff);
  assign w_in_ext   = FIFO_W'(i_in_data & w_in_mask);
  assign w_wr_pos   = w_lvl - w_rd_eff;
  assign w_out_mask = ~({OUT_W{1'b1}} << i_rd_nbits);

  // Only registered storage is visible; same-cycle write data never bypasses.
  assign o_rd_data     = r_storage[OUT_W-1:0] & w_out_mask;
  assign o_level       = r_level;
  assign o_empty       = (r_level == '0);
  assign o_almost_full = (w_lvl >= AF_LIM);

  // Storage/level update: drop consumed LSBs, append new bits above what remains.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_storage <= '0;
      r_level   <= '0;
    end else if (i_flush) begin
      r_storage <= '0;
      r_level   <= '0;
    end else begin
      r_storage <= (r_storage >> w_rd_eff) | (w_in_ext << w_wr_pos);
      r_level   <= CNT_W'(w_wr_pos + w_wr_eff);
    end
  end

`ifdef BIT_FIFO_HS_STATS_EN
  logic [15:0] r_wr_stall, r_rd_stall;
  logic        w_wr_stall, w_rd_stall;

  assign w_wr_stall     = i_in_valid & ~o_in_ready & ~i_flush;
  assign w_rd_stall     = i_rd_req & ~o_rd_valid & ~i_flush;
  assign o_wr_stall_cnt = r_wr_stall;
  assign o_rd_stall_cnt = r_rd_stall;

  // Saturating stall counters; flush clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_stall <= '0;
      r_rd_stall <= '0;
    end else if (i_flush) begin
      r_wr_stall <= '0;
      r_rd_stall <= '0;
    end else begin
      if (w_wr_stall && r_wr_stall != 16'hFFFF) r_wr_stall <= r_wr_stall + 16'd1;
      if (w_rd_stall && r_rd_stall != 16'hFFFF) r_rd_stall <= r_rd_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bit_fifo_hs.sv
// tb_bit_fifo_hs: directed scoreboard bench for bit_fifo_hs (default parameters).
module tb_bit_fifo_hs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [47:0] in_data = '0;
  logic [5:0]  in_nbits = '0;
  logic        in_ready, wr_err;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_nbits = '0;
  logic        rd_valid, rd_err, empty, almost_full;
  logic [47:0] rd_data;
  logic [7:0]  level;
`ifdef BIT_FIFO_HS_STATS_EN
  logic [15:0] wr_stall_cnt, rd_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit sb[$];   // scoreboard of stored bits, front = oldest

  bit_fifo_hs dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .i_in_data(in_data), .i_in_nbits(in_nbits),
    .o_in_ready(in_ready), .o_wr_err(wr_err),
    .i_rd_req(rd_req), .i_rd_nbits(rd_nbits),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_err(rd_err),
    .o_level(level), .o_empty(empty),
`ifdef BIT_FIFO_HS_STATS_EN
    .o_wr_stall_cnt(wr_stall_cnt), .o_rd_stall_cnt(rd_stall_cnt),
`endif
    .o_almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs against the
  // scoreboard model, then apply the model's accept decisions at posedge.
  task automatic cyc(input string tag, input bit iv, input int inn, input logic [47:0] id,
                     input bit rr, input int rn, input bit fl);
    int lvl, reff;
    bit e_rv, e_ir, racc, wacc;
    logic [47:0] e_rd;
    in_valid = iv; in_nbits = 6'(inn); in_data = id;
    rd_req = rr; rd_nbits = 6'(rn); flush = fl;
    #1;
    lvl  = sb.size();
    e_rv = !fl && lvl >= rn && rn <= 48;
    racc = rr && e_rv;
    reff = racc ? rn : 0;
    e_ir = !fl && inn <= 48 && (lvl - reff + inn <= 192);
    wacc = iv && e_ir;
    e_rd = '0;
    for (int i = 0; i < 48; i++) if (i < rn && i < lvl) e_rd[i] = sb[i];
    chk({tag, ".in_ready"}, in_ready, e_ir);
    chk({tag, ".rd_valid"}, rd_valid, e_rv);
    chk({tag, ".rd_data"}, rd_data, e_rd);
    chk({tag, ".wr_err"}, wr_err, iv && inn > 48);
    chk({tag, ".rd_err"}, rd_err, rr && rn > 48);
    chk({tag, ".level"}, level, lvl);
    chk({tag, ".empty"}, empty, lvl == 0);
    chk({tag, ".afull"}, almost_full, lvl >= 144);
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      for (int i = 0; i < reff; i++) void'(sb.pop_front());
      if (wacc) for (int i = 0; i < inn; i++) sb.push_back(id[i]);
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 48, '0, 0, 1, 0);
  endtask

  initial begin
    // 1. Reset state
    #12;
    chk("rst.level", level, 0);
    chk("rst.empty", empty, 1);
    chk("rst.afull", almost_full, 0);
    rst_n = 1'b1;
    @(negedge clk);
    in_nbits = 6'd48; rd_nbits = 6'd1; #1;
    chk("t1.in_ready", in_ready, 1);
    chk("t1.rd_valid", rd_valid, 0);
    idle("t1");

    // 2. Small writes, then two 8-bit reads with explicit expectations
    cyc("t2.w12", 1, 12, 48'hABC, 0, 0, 0);
    cyc("t2.w4", 1, 4, 48'hFFFF_5, 0, 0, 0);
    chk("t2.lvl16", level, 16);
    rd_req = 1; rd_nbits = 6'd8; #1;
    chk("t2.rd0", rd_data, 48'hBC);
    cyc("t2.r8a", 0, 0, '0, 1, 8, 0);
    rd_req = 1; rd_nbits = 6'd8; #1;
    chk("t2.rd1", rd_data, 48'h5A);
    cyc("t2.r8b", 0, 0, '0, 1, 8, 0);
    chk("t2.empty", empty, 1);

    // 3. Fill to capacity, full-rate read+write, drain
    cyc("t3.w0", 1, 48, 48'h1111_2222_3333, 0, 0, 0);
    cyc("t3.w1", 1, 48, 48'h4444_5555_6666, 0, 0, 0);
    cyc("t3.w2", 1, 48, 48'h7777_8888_9999, 0, 0, 0);
    cyc("t3.w3", 1, 48, 48'hAAAA_BBBB_CCCC, 0, 0, 0);
    chk("t3.lvl192", level, 192);
    chk("t3.afull", almost_full, 1);
    cyc("t3.w1bit", 1, 1, 48'h1, 0, 0, 0);
    cyc("t3.rw", 1, 48, 48'hDDDD_EEEE_FFFF, 1, 48, 0);
    chk("t3.lvlkeep", level, 192);
    for (int k = 0; k < 4; k++) cyc("t3.drain", 0, 0, '0, 1, 48, 0);
    chk("t3.empty", empty, 1);

    // 4. Insufficient level blocks a read until enough bits arrive
    cyc("t4.w5", 1, 5, 48'h15, 0, 0, 0);
    cyc("t4.r8blk", 0, 0, '0, 1, 8, 0);
    chk("t4.lvl5", level, 5);
    cyc("t4.w3", 1, 3, 48'h6, 0, 0, 0);
    cyc("t4.r8", 0, 0, '0, 1, 8, 0);

    // 5. Flush blocks same-cycle write and clears storage
    cyc("t5.w40", 1, 40, 48'hFF_1234_5678, 0, 0, 0);
    cyc("t5.flush", 1, 10, 48'h3FF, 0, 0, 1);
    chk("t5.lvl0", level, 0);
    cyc("t5.peek", 0, 0, '0, 0, 48, 0);

    // 6. Oversize requests raise errors and change nothing
    cyc("t6.w20", 1, 20, 48'hF_0F0F, 0, 0, 0);
    cyc("t6.werr", 1, 49, 48'hFFFF_FFFF_FFFF, 0, 0, 0);
    cyc("t6.rerr", 0, 0, '0, 1, 49, 0);
    chk("t6.lvl20", level, 20);
    cyc("t6.zero", 1, 0, 48'hFFFF, 1, 0, 0);

    // Mixed random traffic against the scoreboard
    for (int k = 0; k < 60; k++)
      cyc("rnd", 1'($urandom), int'($urandom_range(0, 48)), {$urandom, $urandom},
          1'($urandom), int'($urandom_range(0, 48)), ($urandom_range(0, 19) == 0));

    // Reset mid-transfer clears immediately
    in_valid = 1; in_nbits = 6'd8; in_data = 48'hAA;
    #1 rst_n = 1'b0; #1;
    sb.delete();
    chk("rst2.level", level, 0);
    chk("rst2.empty", empty, 1);
    @(negedge clk); rst_n = 1'b1;
    idle("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
